// File: rtl/parent_link_arbiter.sv
// Packet-level round-robin arbiter sharing one parent TX link between NUM_REQ sources.
// The grant is held for a whole packet; the winning word is registered onto a valid/ready output.
module parent_link_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 64,
    parameter int SRC_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [SRC_WIDTH-1:0]          out_src,
    input  logic                          out_ready,
    output logic                          busy,
    output logic [15:0]                   pkt_count
);

    typedef enum logic {IDLE, OWN} state_t;

    localparam logic [SRC_WIDTH:0]   NUM_REQ_W = (SRC_WIDTH+1)'(NUM_REQ);
    localparam logic [SRC_WIDTH-1:0] LAST_IDX  = SRC_WIDTH'(NUM_REQ - 1);

    state_t                 state_reg, state_next;
    logic [SRC_WIDTH-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [SRC_WIDTH-1:0]   owner_reg, owner_next;
    logic [DATA_WIDTH-1:0]  out_data_reg;
    logic                   out_valid_reg;
    logic                   out_last_reg;
    logic [SRC_WIDTH-1:0]   out_src_reg;
    logic [15:0]            pkt_count_reg;

    logic [DATA_WIDTH-1:0]  req_word [NUM_REQ];
    logic [SRC_WIDTH-1:0]   winner;
    logic                   any_valid;
    logic [SRC_WIDTH-1:0]   sel;
    logic                   grant_active;
    logic                   space;
    logic                   xfer;

    function automatic logic [SRC_WIDTH-1:0] next_idx(input logic [SRC_WIDTH-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Scan downward so the last hit is the closest requester at or after rr_ptr.
    always_comb begin
        logic [SRC_WIDTH:0] idx;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr_reg} + (SRC_WIDTH+1)'(k);
            if (idx >= NUM_REQ_W) idx = idx - NUM_REQ_W;
            if (req_valid[idx[SRC_WIDTH-1:0]]) begin
                winner    = idx[SRC_WIDTH-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign sel          = (state_reg == OWN) ? owner_reg : winner;
    assign grant_active = (state_reg == OWN) || any_valid;
    assign space        = !out_valid_reg || out_ready;
    assign xfer         = !reset && grant_active && space && req_valid[sel];

    always_comb begin
        req_ready = '0;
        if (!reset && grant_active) req_ready[sel] = space;
    end

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        owner_next  = owner_reg;
        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    if (req_last[sel]) begin
                        rr_ptr_next = next_idx(sel);
                    end else begin
                        state_next = OWN;
                        owner_next = sel;
                    end
                end
            end
            OWN: begin
                if (xfer && req_last[sel]) begin
                    state_next  = IDLE;
                    rr_ptr_next = next_idx(sel);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            owner_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_src_reg   <= '0;
            pkt_count_reg <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            owner_reg  <= owner_next;
            if (xfer) begin
                out_data_reg  <= req_word[sel];
                out_last_reg  <= req_last[sel];
                out_src_reg   <= sel;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (out_valid_reg && out_ready && out_last_reg)
                pkt_count_reg <= pkt_count_reg + 16'd1;
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_src   = out_src_reg;
    assign pkt_count = pkt_count_reg;
    assign busy      = (state_reg == OWN) || out_valid_reg;

endmodule

// File: tb/tb_parent_link_arbiter.sv
// Bench for parent_link_arbiter: directed scenarios plus randomized traffic
// checked against a packet-level reference model.
module tb_parent_link_arbiter;

    localparam int N  = 3;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_last;
    logic [1:0]      out_src;
    logic            out_ready;
    logic            busy;
    logic [15:0]     pkt_count;

    int total = 0;
    int bad   = 0;

    parent_link_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_src(out_src),
        .out_ready(out_ready), .busy(busy), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive(input int i, input logic v, input logic l, input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_last[i]         = l;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        do_reset();
        reset     = 1'b1;
        req_valid = 3'b111;
        #1;
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_data !== 64'd0 || out_last !== 1'b0 || out_src !== 2'd0) begin bad++; $display("FAIL reset_out got=%h/%b/%0d exp=0/0/0", out_data, out_last, out_src); end
        total++; if (pkt_count !== 16'd0 || busy !== 1'b0) begin bad++; $display("FAIL reset_cnt_busy got=%0d/%b exp=0/0", pkt_count, busy); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [DW-1:0] a [3];
        do_reset();
        for (int k = 0; k < 3; k++) a[k] = 64'hA0A0_0000_0000_0000 + 64'(k);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1, k == 2, a[k]);
            #1;
            total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL single_ready w%0d got=%b exp=010", k, req_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== a[k] || out_src !== 2'd1 || out_last !== (k == 2))
                begin bad++; $display("FAIL single_word w%0d got=%b/%h/%0d/%b exp=1/%h/1/%b", k, out_valid, out_data, out_src, out_last, a[k], k == 2); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy w%0d got=%b exp=1", k, busy); end
        end
        drive(1, 1'b0, 1'b0, '0);
        tick();
        total++; if (out_valid !== 1'b0 || busy !== 1'b0 || pkt_count !== 16'd1)
            begin bad++; $display("FAIL single_end got=%b/%b/%0d exp=0/0/1", out_valid, busy, pkt_count); end
        $display("test_single done");
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b1, 64'(i + 16));
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++; if (out_valid !== 1'b1 || out_src !== 2'((k - 1) % 3) || out_data !== 64'((k - 1) % 3 + 16))
                begin bad++; $display("FAIL rr_seq k=%0d got=%b/%0d exp=1/%0d", k, out_valid, out_src, (k - 1) % 3); end
        end
        req_valid = '0;
        $display("test_round_robin done");
    endtask

    task automatic test_packet_lock();
        do_reset();
        drive(2, 1'b1, 1'b1, 64'hC2);
        for (int k = 0; k < 6; k++) begin
            // words at steps 0,1,4,5; steps 2,3 are the owner's bubble
            int w;
            w = (k < 2) ? k : k - 2;
            if (k == 2 || k == 3) drive(0, 1'b0, 1'b0, '0);
            else drive(0, 1'b1, w == 3, 64'hB000 + 64'(w));
            #1;
            total++; if (req_ready[2] !== 1'b0) begin bad++; $display("FAIL lock_ready2 step=%0d got=%b exp=0", k, req_ready[2]); end
            tick();
            if (k == 2 || k == 3) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lock_gap step=%0d got=%b exp=0", k, out_valid); end
            end else begin
                total++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 64'hB000 + 64'(w))
                    begin bad++; $display("FAIL lock_word step=%0d got=%b/%0d/%h exp=1/0/%h", k, out_valid, out_src, out_data, 64'hB000 + 64'(w)); end
            end
        end
        drive(0, 1'b0, 1'b0, '0);
        tick();
        total++; if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 64'hC2)
            begin bad++; $display("FAIL lock_after got=%b/%0d/%h exp=1/2/c2", out_valid, out_src, out_data); end
        req_valid = '0;
        $display("test_packet_lock done");
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1, 1'b1, 1'b0, 64'hD0 + 64'(k));
            tick();
        end
        out_ready = 1'b0;
        drive(1, 1'b1, 1'b0, 64'hD2);
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL bp_ready c=%0d got=%b exp=000", k, req_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || out_data !== 64'hD1) begin bad++; $display("FAIL bp_hold c=%0d got=%b/%h exp=1/d1", k, out_valid, out_data); end
        end
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 64'hD2) begin bad++; $display("FAIL bp_resume got=%b/%h exp=1/d2", out_valid, out_data); end
        drive(1, 1'b1, 1'b1, 64'hD3);
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 64'hD3 || out_last !== 1'b1) begin bad++; $display("FAIL bp_last got=%b/%h/%b exp=1/d3/1", out_valid, out_data, out_last); end
        drive(1, 1'b0, 1'b0, '0);
        tick();
        total++; if (out_valid !== 1'b0 || pkt_count !== 16'd1) begin bad++; $display("FAIL bp_end got=%b/%0d exp=0/1", out_valid, pkt_count); end
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        drive(1, 1'b1, 1'b0, 64'hE0);
        tick();
        drive(1, 1'b1, 1'b0, 64'hE1);
        tick();
        drive(1, 1'b1, 1'b0, 64'hE2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (out_valid !== 1'b0 || pkt_count !== 16'd0) begin bad++; $display("FAIL rstmid_out got=%b/%0d exp=0/0", out_valid, pkt_count); end
        drive(0, 1'b1, 1'b1, 64'hF0);
        drive(1, 1'b1, 1'b1, 64'hF1);
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL rstmid_ready got=%b exp=001", req_ready); end
        tick();
        total++; if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 64'hF0) begin bad++; $display("FAIL rstmid_win got=%b/%0d exp=1/0", out_valid, out_src); end
        req_valid = '0;
        $display("test_reset_mid_packet done");
    endtask

    task automatic test_random();
        int rem [N];
        int seq [N];
        int m_ptr, m_owner, m_src, g, idx;
        bit m_own, m_valid, m_last, space, xf;
        logic [DW-1:0] m_data;
        logic [15:0]   m_cnt;
        logic [N-1:0]  exp_ready;
        do_reset();
        for (int i = 0; i < N; i++) begin rem[i] = 0; seq[i] = 0; end
        m_ptr = 0; m_owner = 0; m_src = 0; m_own = 0; m_valid = 0; m_last = 0; m_data = '0; m_cnt = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            out_ready = ($urandom % 4) != 0;
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
                drive(i, ($urandom % 10) < 6, rem[i] == 1, {32'(i), 32'(seq[i])});
            end
            #1;
            space = !m_valid || out_ready;
            g = -1;
            if (m_own) g = m_owner;
            else for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            exp_ready = '0;
            if (g >= 0 && space) exp_ready[g] = 1'b1;
            total++; if (req_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready); end
            total++; if (out_valid !== m_valid || out_last !== m_last) begin bad++; $display("FAIL rnd_vl cyc=%0d got=%b/%b exp=%b/%b", cyc, out_valid, out_last, m_valid, m_last); end
            total++; if (out_data !== m_data || out_src !== 2'(m_src)) begin bad++; $display("FAIL rnd_data cyc=%0d got=%h/%0d exp=%h/%0d", cyc, out_data, out_src, m_data, m_src); end
            total++; if (busy !== (m_own || m_valid) || pkt_count !== m_cnt) begin bad++; $display("FAIL rnd_busy_cnt cyc=%0d got=%b/%0d exp=%b/%0d", cyc, busy, pkt_count, m_own || m_valid, m_cnt); end
            if (m_valid && out_ready && m_last) m_cnt = m_cnt + 16'd1;
            xf = (g >= 0) && space && req_valid[g];
            if (xf) begin
                m_data  = req_data[g*DW +: DW];
                m_last  = req_last[g];
                m_src   = g;
                m_valid = 1'b1;
                if (req_last[g]) begin m_own = 1'b0; m_ptr = (g + 1) % N; end
                else begin m_own = 1'b1; m_owner = g; end
                seq[g]++;
                rem[g]--;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            tick();
        end
        req_valid = '0;
        $display("test_random done");
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b1, 64'(i));
        repeat (65536) @(posedge clk);
        #1;
        total++; if (pkt_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff got=%h exp=ffff", pkt_count); end
        tick();
        total++; if (pkt_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", pkt_count); end
        req_valid = '0;
        $display("test_counter_wrap done");
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
